// File: rtl/level_debounce_pulse_synch.sv
// level_debounce_pulse_synch: debounces an async level into a clean level plus one-cycle rise/fall pulses
module level_debounce_pulse_synch #(
  parameter int par_T_debounce_bits = 7,
  parameter int par_T_debounce_val  = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_x,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_RISE_WAIT = 2'b01,
    ST_HIGH      = 2'b11,
    ST_FALL_WAIT = 2'b10
  } state_t;
  localparam logic [par_T_debounce_bits-1:0] c_tmax = par_T_debounce_bits'(par_T_debounce_val - 1);
  logic s_meta, s_sync;
  state_t pr, nx;
  logic [par_T_debounce_bits-1:0] s_t;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      pr     <= ST_LOW;
      s_t    <= '0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      s_meta <= i_x;
      s_sync <= s_meta;
      pr     <= nx;
      s_t    <= (pr != nx) ? '0 : (s_t >= c_tmax) ? c_tmax : s_t + 1'b1;
      o_rise <= (pr == ST_RISE_WAIT) && (nx == ST_HIGH);
      o_fall <= (pr == ST_FALL_WAIT) && (nx == ST_LOW);
    end
  end
  // a glitch back to the held level outranks timer expiry
  always_comb begin
    nx = ST_LOW;
    case (pr)
      ST_LOW:       nx = s_sync ? ST_RISE_WAIT : ST_LOW;
      ST_RISE_WAIT: nx = !s_sync ? ST_LOW : (s_t >= c_tmax) ? ST_HIGH : ST_RISE_WAIT;
      ST_HIGH:      nx = !s_sync ? ST_FALL_WAIT : ST_HIGH;
      ST_FALL_WAIT: nx = s_sync ? ST_HIGH : (s_t >= c_tmax) ? ST_LOW : ST_FALL_WAIT;
      default:      nx = ST_LOW;
    endcase
  end
  assign o_level = (pr == ST_HIGH) || (pr == ST_FALL_WAIT);
endmodule

// File: tb/tb_level_debounce_pulse_synch.sv
// tb_level_debounce_pulse_synch: table vectors, corner sequences and random runs against a run-length model
module tb_level_debounce_pulse_synch;
  localparam int N = 4;
  logic i_clk = 1'b0, i_rst = 1'b1, i_x = 1'b0;
  logic o_level, o_rise, o_fall;
  int errors = 0, checks = 0, cyc = 0, n_rise = 0, n_fall = 0, last_rise = -1;
  bit lv, q1, q2, m_rise, m_fall;
  int cnt;
  typedef struct {
    logic rst, x, lvl, rise, fall;
  } vec_t;
  vec_t tbl[16] = '{
    '{1, 0, 0, 0, 0},
    '{0, 1, 0, 0, 0}, '{0, 1, 0, 0, 0}, '{0, 1, 0, 0, 0},
    '{0, 1, 0, 0, 0}, '{0, 1, 0, 0, 0}, '{0, 1, 0, 0, 0},
    '{0, 1, 1, 1, 0},
    '{0, 0, 1, 0, 0}, '{0, 0, 1, 0, 0}, '{0, 0, 1, 0, 0},
    '{0, 0, 1, 0, 0}, '{0, 0, 1, 0, 0}, '{0, 0, 1, 0, 0},
    '{0, 0, 0, 0, 1},
    '{0, 0, 0, 0, 0}
  };

  level_debounce_pulse_synch #(.par_T_debounce_bits(3), .par_T_debounce_val(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_x(i_x),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // model: a new level is accepted once N+1 consecutive samples differ from it,
  // and the outputs show that decision two edges later (synchronizer depth)
  task automatic step(input logic x, input logic r);
    i_x = x;
    i_rst = r;
    @(posedge i_clk);
    cyc++;
    if (r) begin
      lv = 0; cnt = 0; q1 = 0; q2 = 0; m_rise = 0; m_fall = 0;
    end else begin
      m_rise = q1 & ~q2;
      m_fall = ~q1 & q2;
      q2 = q1;
      q1 = lv;
      if (x != lv) begin
        cnt++;
        if (cnt == N + 1) begin
          lv = x;
          cnt = 0;
        end
      end else cnt = 0;
    end
    #1;
    check("level", o_level, q2);
    check("rise", o_rise, m_rise);
    check("fall", o_fall, m_fall);
    n_rise += o_rise;
    n_fall += o_fall;
    if (o_rise) last_rise = cyc;
  endtask

  initial begin
    int k;
    logic x;
    step(0, 1);
    step(0, 1);
    n_rise = 0; n_fall = 0;
    for (int i = 0; i < 20; i++) step(0, 0);
    check("idle_rise_count", n_rise, 0);
    check("idle_fall_count", n_fall, 0);
    check("idle_level", o_level, 0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].x, tbl[i].rst);
      check($sformatf("tbl%0d_level", i), o_level, tbl[i].lvl);
      check($sformatf("tbl%0d_rise", i), o_rise, tbl[i].rise);
      check($sformatf("tbl%0d_fall", i), o_fall, tbl[i].fall);
    end

    n_rise = 0;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) step(1, 0);
      for (int i = 0; i < 6; i++) step(0, 0);
    end
    check("short_press_rises", n_rise, 0);
    check("short_press_level", o_level, 0);
    step(1, 0); step(0, 0); step(1, 0); step(0, 0);
    step(1, 0);
    k = cyc;
    for (int i = 0; i < 12; i++) step(1, 0);
    check("bounce_rises", n_rise, 1);
    check("bounce_latency", last_rise - k, N + 2);

    for (int i = 0; i < 12; i++) step(0, 0);
    check("released_level", o_level, 0);
    n_rise = 0; n_fall = 0;
    for (int i = 0; i < 5; i++) step(1, 0);
    step(1, 1);
    check("rst_mid_level", o_level, 0);
    check("rst_mid_rise", o_rise, 0);
    check("rst_mid_fall", o_fall, 0);
    step(1, 0);
    k = cyc;
    for (int i = 0; i < 12; i++) step(1, 0);
    check("rst_mid_rises", n_rise, 1);
    check("rst_mid_latency", last_rise - k, N + 2);
    check("rst_mid_falls", n_fall, 0);

    for (int i = 0; i < 12; i++) step(0, 0);
    n_rise = 0; n_fall = 0;
    for (int i = 0; i < 100; i++) step(((i / 3) % 2) == 0, 0);
    check("toggle_rises", n_rise, 0);
    check("toggle_falls", n_fall, 0);
    check("toggle_level", o_level, 0);
    for (int i = 0; i < 12; i++) step(1, 0);
    check("toggle_hold_rises", n_rise, 1);
    check("toggle_hold_level", o_level, 1);

    x = 0;
    for (int i = 0; i < 600;) begin
      int len;
      len = $urandom_range(1, 2 * N + 2);
      x = ~x;
      for (int j = 0; j < len; j++) begin
        step(x, $urandom_range(0, 79) == 0);
        i++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
